// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter: start bit, WIDTH data bits LSB first,
// optional even-parity bit, stop bit. Every output is registered.
module piso_tx #(
   parameter int WIDTH        = 8,
   parameter int CLKS_PER_BIT = 4,
   parameter int PARITY_EN    = 1
) (
   input  logic             CLK,
   input  logic             CLR,
   input  logic [WIDTH-1:0] D,
   input  logic             LOAD,
   output logic             READY,
   output logic             Q,
   output logic             BUSY,
   output logic             DONE,
   output logic [2:0]       fsm_state
);
   typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

   localparam logic [7:0] CNT_LAST = 8'(CLKS_PER_BIT - 1);
   localparam logic [4:0] IDX_LAST = 5'(WIDTH - 1);

   state_t           state, state_n;
   logic [7:0]       cnt, cnt_n;
   logic [4:0]       idx, idx_n;
   logic [WIDTH-1:0] shreg, shreg_n;
   logic             par, par_n;
   logic             q_n, done_n, ready_n;
   logic             bit_end;

   assign bit_end   = (cnt == CNT_LAST);
   assign fsm_state = state;

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      idx_n   = idx;
      shreg_n = shreg;
      par_n   = par;
      case (state)
         IDLE: begin
            if (LOAD) begin
               state_n = START;
               shreg_n = D;
               par_n   = ^D;
               cnt_n   = '0;
               idx_n   = '0;
            end
         end
         START: begin
            if (bit_end) begin
               state_n = DATA;
               cnt_n   = '0;
               idx_n   = '0;
            end else begin
               cnt_n = cnt + 8'd1;
            end
         end
         DATA: begin
            if (bit_end) begin
               cnt_n   = '0;
               shreg_n = shreg >> 1;
               if (idx == IDX_LAST) begin
                  state_n = (PARITY_EN != 0) ? PAR : STOP;
               end else begin
                  idx_n = idx + 5'd1;
               end
            end else begin
               cnt_n = cnt + 8'd1;
            end
         end
         PAR: begin
            if (bit_end) begin
               state_n = STOP;
               cnt_n   = '0;
            end else begin
               cnt_n = cnt + 8'd1;
            end
         end
         STOP: begin
            if (bit_end) begin
               state_n = IDLE;
               cnt_n   = '0;
            end else begin
               cnt_n = cnt + 8'd1;
            end
         end
         default: state_n = IDLE;
      endcase

      // Outputs are computed from the next state so the registered line
      // lines up with the state it describes.
      case (state_n)
         START:   q_n = 1'b0;
         DATA:    q_n = shreg_n[0];
         PAR:     q_n = par_n;
         default: q_n = 1'b1;
      endcase
      done_n  = (state_n == STOP) && (cnt_n == CNT_LAST);
      ready_n = (state_n == IDLE);
   end

   always_ff @(posedge CLK) begin
      if (CLR) begin
         state <= IDLE;
         cnt   <= '0;
         idx   <= '0;
         shreg <= '0;
         par   <= 1'b0;
         Q     <= 1'b1;
         READY <= 1'b1;
         BUSY  <= 1'b0;
         DONE  <= 1'b0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         idx   <= idx_n;
         shreg <= shreg_n;
         par   <= par_n;
         Q     <= q_n;
         READY <= ready_n;
         BUSY  <= !ready_n;
         DONE  <= done_n;
      end
   end
endmodule

// File: tb/tb_piso_tx.sv
// Bench for piso_tx: three builds (default, no parity, one clock per bit) share
// the same stimulus; each has a frame-queue model checked every cycle.
module tb_piso_tx;
   logic       CLK = 1'b0;
   logic       CLR;
   logic       LOAD;
   logic [7:0] D;
   logic [2:0] q_w, ready_w, busy_w, done_w;
   logic [2:0] st_w [3];

   int n_cmp = 0;
   int n_bad = 0;

   always #5 CLK = ~CLK;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   for (genvar g = 0; g < 3; g++) begin : m
      localparam int CPB = (g == 2) ? 1 : 4;
      localparam int PE  = (g == 1) ? 0 : 1;

      piso_tx #(.WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(PE)) dut (
         .CLK(CLK), .CLR(CLR), .D(D), .LOAD(LOAD),
         .READY(ready_w[g]), .Q(q_w[g]), .BUSY(busy_w[g]), .DONE(done_w[g]),
         .fsm_state(st_w[g])
      );

      // Expected serial line, one entry per clock of the frame in flight.
      logic fq[$];
      bit   armed = 1'b0;
      logic v;

      always @(posedge CLK) begin
         if (CLR) begin
            fq.delete();
            armed = 1'b1;
         end else if (fq.size() != 0) begin
            void'(fq.pop_front());
         end else if (LOAD && armed) begin
            for (int b = 0; b < 10 + PE; b++) begin
               if (b == 0)                v = 1'b0;
               else if (b <= 8)           v = D[b-1];
               else if (b == 9 && PE == 1) v = ^D;
               else                       v = 1'b1;
               for (int c = 0; c < CPB; c++) fq.push_back(v);
            end
         end
      end

      always @(negedge CLK) begin
         if (armed) begin
            if (fq.size() != 0) begin
               chk($sformatf("q%0d", g),     32'(q_w[g]),     32'(fq[0]));
               chk($sformatf("ready%0d", g), 32'(ready_w[g]), 32'd0);
               chk($sformatf("busy%0d", g),  32'(busy_w[g]),  32'd1);
               chk($sformatf("done%0d", g),  32'(done_w[g]),  32'(fq.size() == 1));
            end else begin
               chk($sformatf("q%0d", g),     32'(q_w[g]),     32'd1);
               chk($sformatf("ready%0d", g), 32'(ready_w[g]), 32'd1);
               chk($sformatf("busy%0d", g),  32'(busy_w[g]),  32'd0);
               chk($sformatf("done%0d", g),  32'(done_w[g]),  32'd0);
            end
         end
      end
   end

   // Returns on the negedge of the first frame cycle, with D scrambled.
   task automatic send(input logic [7:0] val);
      @(negedge CLK);
      D    = val;
      LOAD = 1'b1;
      @(negedge CLK);
      LOAD = 1'b0;
      D    = ~val;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge CLK);
   endtask

   logic [10:0] a5_seq = 11'b10101001010;
   logic [10:0] s96_seq = 11'b10100101100;
   logic [7:0]  c3_val = 8'hC3;

   initial begin
      CLR  = 1'b1;
      LOAD = 1'b0;
      D    = 8'h00;
      repeat (2) @(negedge CLK);
      CLR = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(negedge CLK);
         chk("idle_q", 32'(q_w[0]), 32'd1);
         chk("idle_ready", 32'(ready_w[0]), 32'd1);
         chk("idle_done", 32'(done_w[0]), 32'd0);
      end

      // A5 frame: literal line pattern, DONE timing on both 4-clock builds.
      send(8'hA5);
      for (int k = 1; k <= 45; k++) begin
         if (k > 1) @(negedge CLK);
         if (k <= 44) chk("a5_q", 32'(q_w[0]), 32'(a5_seq[(k-1)/4]));
         chk("a5_done", 32'(done_w[0]), 32'(k == 44));
         chk("np_done", 32'(done_w[1]), 32'(k == 40));
      end
      chk("a5_ready45", 32'(ready_w[0]), 32'd1);
      idle(10);

      send(8'h01);
      for (int k = 2; k <= 38; k++) @(negedge CLK);
      chk("par_01", 32'(q_w[0]), 32'd1);
      idle(10);
      send(8'h00);
      for (int k = 2; k <= 38; k++) @(negedge CLK);
      chk("par_00", 32'(q_w[0]), 32'd0);
      idle(10);

      send(8'h96);
      for (int k = 1; k <= 12; k++) begin
         if (k > 1) @(negedge CLK);
         if (k <= 11) chk("s96_q", 32'(q_w[2]), 32'(s96_seq[k-1]));
         chk("s96_done", 32'(done_w[2]), 32'(k == 11));
      end
      chk("s96_ready", 32'(ready_w[2]), 32'd1);
      idle(40);

      // LOAD held high across two frames.
      @(negedge CLK);
      D    = 8'h3C;
      LOAD = 1'b1;
      @(negedge CLK);
      D = 8'hC3;
      for (int k = 1; k <= 89; k++) begin
         if (k > 1) @(negedge CLK);
         chk("b2b_ready", 32'(ready_w[0]), 32'(k == 45));
         if (k >= 51 && k <= 79 && ((k - 51) % 4 == 0))
            chk("b2b_c3", 32'(q_w[0]), 32'(c3_val[(k-51)/4]));
      end
      LOAD = 1'b0;
      idle(60);

      // LOAD pulse mid-frame must be ignored.
      send(8'h3C);
      idle(9);
      D    = 8'hFF;
      LOAD = 1'b1;
      @(negedge CLK);
      LOAD = 1'b0;
      idle(50);

      // Abort during data bit 3.
      send(8'hFF);
      idle(17);
      CLR = 1'b1;
      @(negedge CLK);
      CLR = 1'b0;
      chk("abort_q", 32'(q_w[0]), 32'd1);
      chk("abort_ready", 32'(ready_w[0]), 32'd1);
      chk("abort_done", 32'(done_w[0]), 32'd0);
      idle(20);
      send(8'h55);
      idle(50);

      // CLR wins over LOAD on the same edge.
      @(negedge CLK);
      CLR  = 1'b1;
      LOAD = 1'b1;
      D    = 8'hAA;
      @(negedge CLK);
      CLR  = 1'b0;
      LOAD = 1'b0;
      chk("clr_load_ready", 32'(ready_w[0]), 32'd1);
      chk("clr_load_busy", 32'(busy_w[0]), 32'd0);
      idle(5);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
